// File: rtl/viterbi_burst_channel_pkg.sv
// Shared types and constants for the burst-error channel model.
// The channel sits between the convolutional encoder and the Viterbi decoder.
package viterbi_chan_pkg;

   typedef enum logic [1:0] {CH_OFF, CH_FIXED, CH_RAND, CH_BER} chan_mode_t;

   localparam logic [15:0] LFSR_POLY    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
      return c;
   endfunction

endpackage

// File: rtl/viterbi_burst_channel_if.sv
// Symbol, configuration and status bundle of the burst-error channel.
// master drives symbols and configuration; slave is the channel itself.
interface viterbi_burst_channel_if #(
   parameter int W     = 2,
   parameter int LOG2P = 5,
   parameter int MAXB  = 8
) ();
   logic                         enable_i;
   logic [W-1:0]                 d_in;
   logic [1:0]                   mode_i;
   logic [W-1:0]                 lane_mask_i;
   logic [$clog2(MAXB+1)-1:0]    burst_len_i;
   logic [LOG2P-1:0]             start_i;
   logic [15:0]                  ber_thr_i;
   logic                         clr_i;
   logic                         valid_o;
   logic [W-1:0]                 d_out;
   logic [W-1:0]                 err_o;
   logic [31:0]                  burst_ct_o;
   logic [31:0]                  bit_err_o;

   modport master (
      output enable_i, d_in, mode_i, lane_mask_i, burst_len_i, start_i, ber_thr_i, clr_i,
      input  valid_o, d_out, err_o, burst_ct_o, bit_err_o
   );

   modport slave (
      input  enable_i, d_in, mode_i, lane_mask_i, burst_len_i, start_i, ber_thr_i, clr_i,
      output valid_o, d_out, err_o, burst_ct_o, bit_err_o
   );
endinterface

// File: rtl/viterbi_burst_channel_lfsr16.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that steps only when adv is high.
// A zero state is unreachable by shifting, so it is forced back to SEED as a safety net.
module chan_lfsr16
   import viterbi_chan_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        adv,
   output logic [15:0] q
);
   logic [15:0] q_reg;
   logic [15:0] q_next;

   always_comb begin
      q_next = {1'b0, q_reg[15:1]} ^ (q_reg[0] ? LFSR_POLY : 16'h0000);
      if (q_reg == 16'h0000) q_next = SEED;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_reg <= SEED;
      end else if (adv || (q_reg == 16'h0000)) begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;
endmodule

// File: rtl/viterbi_burst_channel.sv
// Burst/BER error-injection channel: 1-cycle registered pass-through with lane flips,
// window-aligned configuration and saturating burst / flipped-bit counters.
module viterbi_burst_channel
   import viterbi_chan_pkg::*;
#(
   parameter int          W     = 2,
   parameter int          LOG2P = 5,
   parameter int          MAXB  = 8,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input logic                    clk,
   input logic                    rst,
   viterbi_burst_channel_if.slave bus
);
   localparam int LW = $clog2(MAXB + 1);
   localparam int PW = LOG2P + 2;
   localparam logic [PW-1:0] P_EXT = PW'(2 ** LOG2P);

   logic [LOG2P-1:0] pos_reg;
   chan_mode_t       mode_reg;
   logic [W-1:0]     mask_reg;
   logic [LW-1:0]    len_reg;
   logic [LOG2P-1:0] start_reg;
   logic [15:0]      thr_reg;
   logic             trig_reg;
   logic [LOG2P-1:0] off_reg;
   logic             valid_reg;
   logic [W-1:0]     dout_reg;
   logic [W-1:0]     err_reg;
   logic [31:0]      burst_ct_reg;
   logic [31:0]      bit_ct_reg;
   logic [15:0]      lfsr_q;

   logic             first;
   chan_mode_t       mode_eff;
   logic [W-1:0]     mask_eff;
   logic [LW-1:0]    len_eff;
   logic [LOG2P-1:0] start_eff;
   logic [15:0]      thr_eff;
   logic [PW-1:0]    raw_off;
   logic [PW-1:0]    live_len;
   logic [LOG2P-1:0] off_new;
   logic             trig_eff;
   logic [LOG2P-1:0] off_eff;
   logic [LOG2P-1:0] bstart;
   logic             burst_on;
   logic             in_burst;
   logic             hit;
   logic             burst_first;
   logic [W-1:0]     flip;
   logic [3:0]       pop;
   logic [32:0]      bit_sum;

   chan_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk (clk),
      .rst (rst),
      .adv (bus.enable_i),
      .q   (lfsr_q)
   );

   // The pos==0 symbol already uses the live configuration it latches for the window.
   always_comb begin
      first     = (pos_reg == '0);
      mode_eff  = first ? chan_mode_t'(bus.mode_i) : mode_reg;
      mask_eff  = first ? bus.lane_mask_i : mask_reg;
      len_eff   = first ? bus.burst_len_i : len_reg;
      start_eff = first ? bus.start_i : start_reg;
      thr_eff   = first ? bus.ber_thr_i : thr_reg;
      raw_off   = PW'(lfsr_q[LOG2P-1:0]);
      live_len  = PW'(bus.burst_len_i);
      off_new   = ((raw_off + live_len) > P_EXT) ? LOG2P'(P_EXT - live_len) : lfsr_q[LOG2P-1:0];
      trig_eff  = first ? lfsr_q[15] : trig_reg;
      off_eff   = first ? off_new : off_reg;
      bstart    = (mode_eff == CH_RAND) ? off_eff : start_eff;
      burst_on  = (len_eff != '0) &&
                  ((mode_eff == CH_FIXED) || ((mode_eff == CH_RAND) && trig_eff));
      // pos never reaches P, so the end compare truncates bursts at the window edge.
      in_burst  = burst_on && (pos_reg >= bstart) &&
                  (PW'(pos_reg) < (PW'(bstart) + PW'(len_eff)));
      burst_first = bus.enable_i && in_burst && (pos_reg == bstart);
      case (mode_eff)
         CH_FIXED, CH_RAND: hit = in_burst;
         CH_BER:            hit = (lfsr_q < thr_eff);
         default:           hit = 1'b0;
      endcase
      flip    = (bus.enable_i && hit) ? mask_eff : '0;
      pop     = popcount8(8'(flip));
      bit_sum = {1'b0, bit_ct_reg} + 33'(pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pos_reg      <= '0;
         mode_reg     <= CH_OFF;
         mask_reg     <= '0;
         len_reg      <= '0;
         start_reg    <= '0;
         thr_reg      <= '0;
         trig_reg     <= 1'b0;
         off_reg      <= '0;
         valid_reg    <= 1'b0;
         dout_reg     <= '0;
         err_reg      <= '0;
         burst_ct_reg <= '0;
         bit_ct_reg   <= '0;
      end else begin
         valid_reg <= bus.enable_i;
         err_reg   <= flip;
         if (bus.enable_i) begin
            dout_reg <= bus.d_in ^ flip;
            pos_reg  <= pos_reg + LOG2P'(1);
            if (first) begin
               mode_reg  <= chan_mode_t'(bus.mode_i);
               mask_reg  <= bus.lane_mask_i;
               len_reg   <= bus.burst_len_i;
               start_reg <= bus.start_i;
               thr_reg   <= bus.ber_thr_i;
               trig_reg  <= lfsr_q[15];
               off_reg   <= off_new;
            end
         end
         if (bus.clr_i) begin
            burst_ct_reg <= '0;
            bit_ct_reg   <= '0;
         end else if (bus.enable_i) begin
            bit_ct_reg <= bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
            if (burst_first && (burst_ct_reg != 32'hFFFF_FFFF))
               burst_ct_reg <= burst_ct_reg + 32'd1;
         end
      end
   end

   assign bus.valid_o    = valid_reg;
   assign bus.d_out      = dout_reg;
   assign bus.err_o      = err_reg;
   assign bus.burst_ct_o = burst_ct_reg;
   assign bus.bit_err_o  = bit_ct_reg;
endmodule

// File: tb/tb_viterbi_burst_channel.sv
// Directed bench for viterbi_burst_channel (W=2, P=32, MAXB=8, SEED=ACE1).
// Burst positions are hand-derived; BER/RAND windows use a small reference LFSR.
module tb_viterbi_burst_channel;
   import viterbi_chan_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   viterbi_burst_channel_if bus ();

   viterbi_burst_channel dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [15:0] lfsr_nxt(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic en, input logic [1:0] din);
      bus.enable_i = en;
      bus.d_in     = din;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.enable_i = 1'b0;
      bus.clr_i    = 1'b0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   task automatic set_cfg(input logic [1:0] mode, input logic [1:0] mask, input logic [3:0] len,
                          input logic [4:0] start, input logic [15:0] thr);
      bus.mode_i      = mode;
      bus.lane_mask_i = mask;
      bus.burst_len_i = len;
      bus.start_i     = start;
      bus.ber_thr_i   = thr;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  din;
      logic [1:0]  f;
      logic [1:0]  last;
      logic [15:0] m;
      logic        trig;
      int          off;
      int          p;
      int          v;
      int          nflip;
      int          nburst;

      rst = 1'b0;
      bus.enable_i = 1'b0;
      bus.d_in     = '0;
      bus.clr_i    = 1'b0;
      set_cfg(CH_OFF, 2'b00, 4'd0, 5'd0, 16'h0000);
      #12;
      chk("rst_valid", 32'(bus.valid_o), 0);
      chk("rst_dout", 32'(bus.d_out), 0);
      chk("rst_err", 32'(bus.err_o), 0);
      chk("rst_burst_ct", bus.burst_ct_o, 0);
      chk("rst_bit_err", bus.bit_err_o, 0);
      rst = 1'b1;

      // 1: pass-through
      for (int i = 0; i < 8; i++) begin
         din = 2'(i);
         step(1'b1, din);
         chk("t1_valid", 32'(bus.valid_o), 1);
         chk("t1_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, 2'b00, din});
      end
      step(1'b0, 2'b00);
      chk("t1_gap_valid", 32'(bus.valid_o), 0);
      chk("t1_gap_hold", {28'd0, bus.err_o, bus.d_out}, {28'd0, 2'b00, 2'b11});
      chk("t1_burst_ct", bus.burst_ct_o, 0);
      chk("t1_bit_err", bus.bit_err_o, 0);
      $display("t1 pass-through done: checks=%0d errors=%0d", checks, errors);

      // 2: FIXED, bit0 flipped at pos 3..6 in two windows
      do_reset();
      set_cfg(CH_FIXED, 2'b01, 4'd4, 5'd3, 16'h0000);
      for (int i = 0; i < 64; i++) begin
         din = 2'(i * 3);
         p = i % 32;
         f = (p >= 3 && p <= 6) ? 2'b01 : 2'b00;
         step(1'b1, din);
         chk("t2_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, f, din ^ f});
      end
      chk("t2_burst_ct", bus.burst_ct_o, 2);
      chk("t2_bit_err", bus.bit_err_o, 8);
      $display("t2 fixed burst done: checks=%0d errors=%0d", checks, errors);

      // 3: burst at pos 30 truncated by the window end, no wrap to pos 0
      do_reset();
      set_cfg(CH_FIXED, 2'b01, 4'd4, 5'd30, 16'h0000);
      for (int i = 0; i < 33; i++) begin
         din = 2'(i);
         f = (i == 30 || i == 31) ? 2'b01 : 2'b00;
         step(1'b1, din);
         chk("t3_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, f, din ^ f});
      end
      chk("t3_burst_ct", bus.burst_ct_o, 1);
      chk("t3_bit_err", bus.bit_err_o, 2);
      $display("t3 truncation done: checks=%0d errors=%0d", checks, errors);

      // 4: gapped enable, burst at valid symbols 2..4; mid-window start change ignored
      do_reset();
      set_cfg(CH_FIXED, 2'b10, 4'd3, 5'd2, 16'h0000);
      last = 2'b00;
      v = 0;
      for (int c = 0; c < 20; c++) begin
         din = 2'(c * 3 + 1);
         if (c == 8) bus.start_i = 5'd0;
         if (c % 2 == 0) begin
            f = (v >= 2 && v <= 4) ? 2'b10 : 2'b00;
            last = din ^ f;
            v++;
            step(1'b1, din);
            chk("t4_valid", 32'(bus.valid_o), 1);
            chk("t4_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, f, last});
         end else begin
            step(1'b0, din);
            chk("t4_gap_valid", 32'(bus.valid_o), 0);
            chk("t4_gap_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, 2'b00, last});
         end
      end
      chk("t4_burst_ct", bus.burst_ct_o, 1);
      chk("t4_bit_err", bus.bit_err_o, 3);
      $display("t4 gapped enable done: checks=%0d errors=%0d", checks, errors);

      // 5a: BER with thr=0 never flips
      do_reset();
      set_cfg(CH_BER, 2'b11, 4'd0, 5'd0, 16'h0000);
      for (int i = 0; i < 1024; i++) begin
         din = 2'(i);
         step(1'b1, din);
         chk("t5a_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, 2'b00, din});
      end
      chk("t5a_bit_err", bus.bit_err_o, 0);
      $display("t5a ber thr=0 done: checks=%0d errors=%0d", checks, errors);

      // 5b: BER thr=FFFF, mask=11, with gaps; LFSR must hold across gaps
      do_reset();
      set_cfg(CH_BER, 2'b11, 4'd0, 5'd0, 16'hFFFF);
      m = 16'hACE1;
      v = 0;
      nflip = 0;
      for (int c = 0; v < 1024; c++) begin
         if (c % 7 == 6) begin
            step(1'b0, 2'b00);
            chk("t5b_gap_err", 32'(bus.err_o), 0);
         end else begin
            f = (m < 16'hFFFF) ? 2'b11 : 2'b00;
            if (m < 16'hFFFF) nflip++;
            m = lfsr_nxt(m);
            v++;
            step(1'b1, 2'b01);
            chk("t5b_err", 32'(bus.err_o), 32'(f));
         end
      end
      chk("t5b_bit_err", bus.bit_err_o, 32'(2 * nflip));
      chk("t5b_burst_ct", bus.burst_ct_o, 0);
      $display("t5b ber thr=FFFF done: flipped=%0d checks=%0d errors=%0d", nflip, checks, errors);

      // 5c: RAND_BURST, len=5, against the reference LFSR
      do_reset();
      set_cfg(CH_RAND, 2'b01, 4'd5, 5'd0, 16'h0000);
      m = 16'hACE1;
      trig = 1'b0;
      off = 0;
      nflip = 0;
      nburst = 0;
      for (int i = 0; i < 1024; i++) begin
         p = i % 32;
         if (p == 0) begin
            trig = m[15];
            off = int'(m[4:0]);
            if (off + 5 > 32) off = 27;
         end
         f = (trig && p >= off && p < off + 5) ? 2'b01 : 2'b00;
         if (f != 2'b00) nflip++;
         if (f != 2'b00 && p == off) nburst++;
         m = lfsr_nxt(m);
         step(1'b1, 2'b10);
         chk("t5c_err", 32'(bus.err_o), 32'(f));
      end
      chk("t5c_burst_ct", bus.burst_ct_o, 32'(nburst));
      chk("t5c_bit_err", bus.bit_err_o, 32'(nflip));
      $display("t5c rand burst done: bursts=%0d checks=%0d errors=%0d", nburst, checks, errors);

      // 6: clear wins over a coincident flip, then saturation from a forced preload
      do_reset();
      set_cfg(CH_FIXED, 2'b11, 4'd5, 5'd0, 16'h0000);
      bus.clr_i = 1'b1;
      step(1'b1, 2'b00);
      bus.clr_i = 1'b0;
      chk("t6_clr_err", 32'(bus.err_o), 3);
      chk("t6_clr_burst", bus.burst_ct_o, 0);
      chk("t6_clr_bit", bus.bit_err_o, 0);
      step(1'b1, 2'b00);
      chk("t6_after_clr_bit", bus.bit_err_o, 2);
      chk("t6_after_clr_burst", bus.burst_ct_o, 0);
      force dut.bit_ct_reg = 32'hFFFF_FFFE;
      force dut.burst_ct_reg = 32'hFFFF_FFFE;
      #1;
      release dut.bit_ct_reg;
      release dut.burst_ct_reg;
      for (int i = 2; i < 5; i++) begin
         step(1'b1, 2'b00);
         chk("t6_sat_bit", bus.bit_err_o, 32'hFFFF_FFFF);
      end
      for (int i = 5; i < 33; i++) step(1'b1, 2'b00);
      chk("t6_burst_inc", bus.burst_ct_o, 32'hFFFF_FFFF);
      for (int i = 33; i < 65; i++) step(1'b1, 2'b00);
      chk("t6_burst_sat", bus.burst_ct_o, 32'hFFFF_FFFF);
      chk("t6_bit_sat", bus.bit_err_o, 32'hFFFF_FFFF);
      bus.clr_i = 1'b1;
      step(1'b0, 2'b00);
      bus.clr_i = 1'b0;
      chk("t6_clr_burst2", bus.burst_ct_o, 0);
      chk("t6_clr_bit2", bus.bit_err_o, 0);
      $display("t6 counters done: checks=%0d errors=%0d", checks, errors);

      // 6b: async reset in the middle of a burst
      do_reset();
      set_cfg(CH_FIXED, 2'b01, 4'd8, 5'd0, 16'h0000);
      step(1'b1, 2'b00);
      chk("t6b_pre_err0", 32'(bus.err_o), 1);
      step(1'b1, 2'b00);
      chk("t6b_pre_err1", 32'(bus.err_o), 1);
      rst = 1'b0;
      #1;
      chk("t6b_rst_valid", 32'(bus.valid_o), 0);
      chk("t6b_rst_err", 32'(bus.err_o), 0);
      chk("t6b_rst_dout", 32'(bus.d_out), 0);
      chk("t6b_rst_bit", bus.bit_err_o, 0);
      #1;
      rst = 1'b1;
      step(1'b1, 2'b10);
      chk("t6b_restart_sym", {28'd0, bus.err_o, bus.d_out}, {28'd0, 2'b01, 2'b11});
      chk("t6b_restart_burst", bus.burst_ct_o, 1);
      chk("t6b_restart_bit", bus.bit_err_o, 1);
      $display("t6b async reset done: checks=%0d errors=%0d", checks, errors);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
